// File: rtl/ex_mem_stage.sv
// Execute->memory boundary: resolves branches/jumps, raises a one-cycle redirect,
// and buffers beats in a 2-entry skid buffer toward the memory stage.
module ex_mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [DATA_WIDTH-1:0] alu_res_i,
  input  logic                  zero_flag_i,
  input  logic                  ovf_flag_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [5:0]            ctl_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [DATA_WIDTH-1:0] mem_result_o,
  output logic [DATA_WIDTH-1:0] mem_store_o,
  output logic [REG_ADDR_W-1:0] mem_rd_o,
  output logic [2:0]            mem_ctl_o,
  output logic                  mem_ovf_o,
  output logic                  mem_misalign_o,
  output logic                  redirect_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [DATA_WIDTH-1:0] store;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            ctl;
    logic                  ovf;
    logic                  misalign;
  } beat_t;

  beat_t                 e0_q, e0_d, e1_q, e1_d, new_beat;
  logic                  v0_q, v0_d, v1_q, v1_d;
  logic                  ready_q, ready_d;
  logic                  redirect_q, redirect_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic                  is_branch, is_jal, is_jalr;
  logic                  accept, push, pop, taken, misalign;
  logic [DATA_WIDTH-1:0] target;

  assign is_branch = ctl_i[5];
  assign is_jal    = ctl_i[4];
  assign is_jalr   = ctl_i[3];

  // Branch/jump resolution and construction of the beat to enqueue
  always_comb begin
    taken    = is_jal | is_jalr | (is_branch & zero_flag_i);
    target   = is_jalr ? (alu_res_i & ~{{(DATA_WIDTH-1){1'b0}}, 1'b1}) : (pc_i + imm_i);
    misalign = taken & (target[1:0] != 2'b00);
    new_beat.result   = (is_jal | is_jalr) ? (pc_i + DATA_WIDTH'(4)) : alu_res_i;
    new_beat.store    = store_data_i;
    new_beat.rd       = rd_i;
    new_beat.ovf      = ovf_flag_i;
    new_beat.misalign = misalign;
    if (misalign || is_branch) begin
      new_beat.ctl = 3'b000;
    end else begin
      new_beat.ctl = ctl_i[2:0];
    end
  end

  // A beat taken while a redirect is showing is wrong-path: handshake completes, beat is dropped
  assign accept = ex_valid_i & ready_q;
  assign push   = accept & ~redirect_q & ~flush_i;
  assign pop    = v0_q & mem_ready_i;

  // Skid buffer and redirect next-state
  always_comb begin
    e0_d          = e0_q;
    e1_d          = e1_q;
    v0_d          = v0_q;
    v1_d          = v1_q;
    redirect_d    = push & taken & ~misalign;
    redirect_pc_d = redirect_d ? target : redirect_pc_q;
    if (flush_i) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!v0_q) begin
            e0_d = new_beat;
            v0_d = 1'b1;
          end else begin
            e1_d = new_beat;
            v1_d = 1'b1;
          end
        end
        2'b01: begin
          e0_d = e1_q;
          v0_d = v1_q;
          v1_d = 1'b0;
        end
        2'b11: begin
          if (v1_q) begin
            e0_d = e1_q;
            e1_d = new_beat;
          end else begin
            e0_d = new_beat;
            v0_d = 1'b1;
          end
        end
        default: begin
          v0_d = v0_q;
        end
      endcase
    end
    ready_d = ~v1_d;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      e0_q          <= '0;
      e1_q          <= '0;
      v0_q          <= 1'b0;
      v1_q          <= 1'b0;
      ready_q       <= 1'b1;
      redirect_q    <= 1'b0;
      redirect_pc_q <= {DATA_WIDTH{1'b0}};
    end else begin
      e0_q          <= e0_d;
      e1_q          <= e1_d;
      v0_q          <= v0_d;
      v1_q          <= v1_d;
      ready_q       <= ready_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign ex_ready_o     = ready_q;
  assign mem_valid_o    = v0_q;
  assign mem_result_o   = e0_q.result;
  assign mem_store_o    = e0_q.store;
  assign mem_rd_o       = e0_q.rd;
  assign mem_ctl_o      = e0_q.ctl;
  assign mem_ovf_o      = e0_q.ovf;
  assign mem_misalign_o = e0_q.misalign;
  assign redirect_o     = redirect_q;
  assign redirect_pc_o  = redirect_pc_q;

endmodule
